// File: rtl/regfile_dump.sv
// ============================================================================
// regfile_dump : streams an inclusive range of register-file entries over a
//                valid/ready port. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_PRESENT = 2'd2,
    S_FINISH  = 2'd3
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  cur_q;
  logic [ADDR_W-1:0]  last_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [ADDR_W-1:0]  out_index_q;
  logic               out_last_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // done/err are set only on the transition into FINISH, so they last one cycle
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (first_reg <= last_reg) begin
              last_q  <= last_reg;
              cur_q   <= first_reg;
              state_q <= S_READ;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            out_data_q  <= rd_data;
            out_index_q <= cur_q;
            out_last_q  <= (cur_q == last_q);
            out_valid_q <= 1'b1;
            state_q     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              // Only reached with cur < last, so cur cannot wrap past the top index
              cur_q   <= cur_q + ADDR_W'(1);
              state_q <= S_READ;
            end
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_reg    = cur_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width (2^ADDR_W registers).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a dump.
REQ-006 The block SHALL have port first_reg, input, ADDR_W, the first register index of the range, sampled on an accepted start.
REQ-007 The block SHALL have port last_reg, input, ADDR_W, the last register index of the range (inclusive), sampled on an accepted start.
REQ-008 The block SHALL have port abort, input, 1, which terminates the dump in progress.
REQ-009 The block SHALL have port rd_reg, output, ADDR_W, the address driven to the register file read port.
REQ-010 The block SHALL have port rd_data, input, DATA_W, the combinational read data returned for rd_reg.
REQ-011 The block SHALL have port out_valid, output, 1, which indicates that out_data, out_index and out_last are valid.
REQ-012 The block SHALL have port out_ready, input, 1, the downstream acceptance signal.
REQ-013 The block SHALL have port out_data, output, DATA_W, the captured register value.
REQ-014 The block SHALL have port out_index, output, ADDR_W, the index of the register in out_data.
REQ-015 The block SHALL have port out_last, output, 1, asserted when out_index equals the latched last_reg.
REQ-016 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 The block SHALL have port done, output, 1, a one-cycle pulse on completion.
REQ-018 The block SHALL have port err, output, 1, a one-cycle pulse when a range is rejected; it is coincident with done.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, READ, PRESENT and FINISH; all registered outputs SHALL be driven from flops.
REQ-020 In IDLE, if start=1 and first_reg<=last_reg, the block SHALL latch both indices, set cur=first_reg and go to READ.
REQ-021 In IDLE, if start=1 and first_reg>last_reg, the block SHALL go to FINISH with err pending and no words emitted.
REQ-022 rd_reg SHALL equal cur at all times; in IDLE, cur holds its last value.
REQ-023 In READ, the block SHALL register out_data<=rd_data, out_index<=cur and out_last<=(cur==last), set out_valid<=1, and go to PRESENT.
REQ-024 The first out_valid SHALL rise exactly 2 cycles after the start cycle (start at edge N, READ at N+1, valid at N+2).
REQ-025 In PRESENT, while out_ready=0, out_valid, out_data, out_index and out_last SHALL hold stable.
REQ-026 In PRESENT, on out_valid&&out_ready with out_last=0, the block SHALL set out_valid<=0, cur<=cur+1 and go to READ; this gives a minimum of 2 cycles per word.
REQ-027 In PRESENT, on out_valid&&out_ready with out_last=1, the block SHALL set out_valid<=0 and go to FINISH.
REQ-028 FINISH SHALL last exactly one cycle, assert done=1 (plus err=1 if the range was rejected), then return to IDLE.
REQ-029 cur SHALL never increment past the latched last_reg; last_reg at the maximum index (31) SHALL NOT wrap cur to 0.
REQ-030 A range with first_reg==last_reg SHALL emit exactly one word with out_last=1.
REQ-031 start SHALL be ignored while busy=1, with no effect on the latched range.
REQ-032 abort=1 in READ or PRESENT SHALL force out_valid<=0 and return to IDLE next cycle with no done pulse; abort SHALL take priority over a simultaneous handshake.
REQ-033 abort in IDLE or FINISH SHALL have no effect; done still pulses in FINISH.
REQ-034 rd_data SHALL be sampled only in READ; register file writes that occur during PRESENT SHALL NOT alter the presented word.

Reset
REQ-035 On reset=1 at a clock edge, the block SHALL enter IDLE and drive out_valid=0, done=0, err=0, busy=0, cur=0, out_data=0, out_index=0 and out_last=0.
REQ-036 Reset SHALL override start, abort and the handshake when asserted in the same cycle.
REQ-037 Reset asserted mid-dump SHALL discard the transfer without a done pulse.

Verification
REQ-038 Regs r[i]=0xA000_0000+i, start with first=3, last=6, out_ready=1 -> 4 words with indices 3..6 and data 0xA0000003..0xA0000006, out_last on index 6 only, one done pulse, err=0.
REQ-039 first=last=31 -> exactly one word with index 31 and out_last=1; cur never reads 0 afterwards; done pulses once.
REQ-040 first=8, last=2 -> done and err high for the same single cycle, out_valid never asserted, busy high for one cycle.
REQ-041 out_ready held 0 for 5 cycles on the word with index 4 while the regfile writes r4=0xDEADBEEF -> out_data stays at its original value until accepted.
REQ-042 abort asserted during PRESENT of the second word, with out_ready=1 the same cycle -> that word is not counted, out_valid falls, IDLE next cycle, no done pulse.
REQ-043 reset asserted during READ, plus start pulses while busy -> all outputs are at their reset values next cycle, and the ignored start pulses leave the range unchanged.
